// File: rtl/mul_pipe.sv
// Three-stage multiply unit for MUL/MULH/MULHSU/MULHU with valid/ready on both sides.
// The multiplier is a radix-4 Booth array reduced by carry-save adders and a selectable final adder.
module mul_pipe #(
  parameter int WIDTH         = 32,
  parameter int CPA_ALGORITHM = 1,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2 + 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic                 v1_reg, v2_reg, v3_reg;
  logic                 rdy1, rdy2, rdy3;

  logic [1:0]           op1_reg;
  logic [WIDTH-1:0]     a1_reg, b1_reg;
  logic [TAG_WIDTH-1:0] tag1_reg;

  logic [PW-1:0]        prod2_reg;
  logic [1:0]           op2_reg;
  logic [TAG_WIDTH-1:0] tag2_reg;
  logic                 a_msb2_reg;
  logic [WIDTH-1:0]     b2_reg;

  logic [WIDTH-1:0]     res3_reg;
  logic [TAG_WIDTH-1:0] tag3_reg;
  logic [WIDTH-1:0]     res_next;

  // ---------------------------------------------------------------- handshake
  assign rdy3     = ~v3_reg | out_ready;
  assign rdy2     = ~v2_reg | rdy3;
  assign rdy1     = ~v1_reg | rdy2;
  assign in_ready = rdy1 & ~rst & ~flush;

  assign out_valid  = v3_reg;
  assign out_result = res3_reg;
  assign out_tag    = tag3_reg;
  assign busy       = v1_reg | v2_reg | v3_reg;

  // ---------------------------------------------------------------- multiplier
  // Both operands are treated alike: signed for MUL/MULH, unsigned for MULHSU/MULHU.
  logic            unsign;
  logic            b_ext;
  logic [PW-1:0]   mcand;
  logic [WIDTH+2:0] mplier;
  logic [PW-1:0]   pp [ND];
  logic [ND-1:0]   pp_neg;
  logic [PW-1:0]   neg_vec;
  logic [PW-1:0]   acc_s, acc_c, acc_t;
  logic [PW-1:0]   prod;

  assign unsign = op1_reg[1];
  assign mcand  = {{WIDTH{~unsign & a1_reg[WIDTH-1]}}, a1_reg};
  assign b_ext  = ~unsign & b1_reg[WIDTH-1];
  assign mplier = {b_ext, b_ext, b1_reg, 1'b0};

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_booth
      logic [2:0]    dig;
      logic          one;
      logic          two;
      logic [PW-1:0] mag;

      assign dig        = mplier[2*gi+2 -: 3];
      assign one        = dig[1] ^ dig[0];
      assign two        = (dig[2] & ~dig[1] & ~dig[0]) | (~dig[2] & dig[1] & dig[0]);
      assign pp_neg[gi] = dig[2] & ~(dig[1] & dig[0]);
      assign mag        = one ? mcand : (two ? {mcand[PW-2:0], 1'b0} : '0);
      // Negative digits use one's complement here; the +1 lands via neg_vec.
      assign pp[gi]     = (mag ^ {PW{pp_neg[gi]}}) << (2 * gi);
    end
  endgenerate

  always_comb begin
    neg_vec = '0;
    for (int i = 0; i < ND; i++) begin
      neg_vec[2*i] = pp_neg[i];
    end
  end

  always_comb begin
    acc_s = pp[0];
    acc_c = neg_vec;
    acc_t = '0;
    for (int i = 1; i < ND; i++) begin
      acc_t = acc_s ^ acc_c ^ pp[i];
      acc_c = ((acc_s & acc_c) | (acc_s & pp[i]) | (acc_c & pp[i])) << 1;
      acc_s = acc_t;
    end
  end

  generate
    if (CPA_ALGORITHM == 0) begin : g_rca
      always_comb begin
        logic carry;
        carry = 1'b0;
        prod  = '0;
        for (int i = 0; i < PW; i++) begin
          prod[i] = acc_s[i] ^ acc_c[i] ^ carry;
          carry   = (acc_s[i] & acc_c[i]) | (carry & (acc_s[i] ^ acc_c[i]));
        end
      end
    end else begin : g_cla
      // 4-bit lookahead blocks, block carries rippled between blocks.
      always_comb begin
        logic       carry;
        logic [3:0] bp, bg, bc;
        carry = 1'b0;
        prod  = '0;
        bp    = '0;
        bg    = '0;
        bc    = '0;
        for (int blk = 0; blk < PW / 4; blk++) begin
          bp    = acc_s[4*blk +: 4] ^ acc_c[4*blk +: 4];
          bg    = acc_s[4*blk +: 4] & acc_c[4*blk +: 4];
          bc[0] = carry;
          bc[1] = bg[0] | (bp[0] & carry);
          bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & carry);
          bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                | (bp[2] & bp[1] & bp[0] & carry);
          carry = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                | (bp[3] & bp[2] & bp[1] & bg[0]) | ((&bp) & carry);
          prod[4*blk +: 4] = bp ^ bc;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- result select
  // MULHSU is computed unsigned x unsigned; subtract b from the upper half when a is negative.
  always_comb begin
    res_next = prod2_reg[PW-1:WIDTH];
    case (op2_reg)
      OP_MUL:    res_next = prod2_reg[WIDTH-1:0];
      OP_MULHSU: res_next = prod2_reg[PW-1:WIDTH] - (a_msb2_reg ? b2_reg : '0);
      OP_MULH,
      OP_MULHU:  res_next = prod2_reg[PW-1:WIDTH];
      default:   res_next = prod2_reg[PW-1:WIDTH];
    endcase
  end

  // ---------------------------------------------------------------- stage valids
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (rdy1) v1_reg <= in_valid;
      if (rdy2) v2_reg <= v1_reg;
      if (rdy3) v3_reg <= v2_reg;
    end
  end

  // ---------------------------------------------------------------- stage data
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_reg    <= '0;
      a1_reg     <= '0;
      b1_reg     <= '0;
      tag1_reg   <= '0;
      prod2_reg  <= '0;
      op2_reg    <= '0;
      tag2_reg   <= '0;
      a_msb2_reg <= 1'b0;
      b2_reg     <= '0;
      res3_reg   <= '0;
      tag3_reg   <= '0;
    end else begin
      if (rdy1) begin
        op1_reg  <= in_op;
        a1_reg   <= in_a;
        b1_reg   <= in_b;
        tag1_reg <= in_tag;
      end
      if (rdy2) begin
        prod2_reg  <= prod;
        op2_reg    <= op1_reg;
        tag2_reg   <= tag1_reg;
        a_msb2_reg <= a1_reg[WIDTH-1];
        b2_reg     <= b1_reg;
      end
      if (rdy3) begin
        res3_reg <= res_next;
        tag3_reg <= tag2_reg;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed vectors, stall/reset/flush scenarios and a
// scoreboarded random run, applied to one ripple-carry and one lookahead instance in parallel.
module tb_mul_pipe;

  localparam int W     = 32;
  localparam int TW    = 5;
  localparam int NRAND = 800;
  localparam int NFULL = 200;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;

  logic          in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [W-1:0]  out_result0, out_result1;
  logic [TW-1:0] out_tag0, out_tag1;

  int checks   = 0;
  int failures = 0;

  logic [TW+W-1:0] sb_q [$];
  int              sent, recv, cyc;
  logic [TW-1:0]   tag_ctr;

  logic [1:0]  d_op  [4];
  logic [31:0] d_a   [4];
  logic [31:0] d_b   [4];
  logic [31:0] d_exp [4];

  always #5 clk = ~clk;

  mul_pipe #(.WIDTH(W), .CPA_ALGORITHM(0), .TAG_WIDTH(TW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid0),
    .out_ready(out_ready), .out_result(out_result0), .out_tag(out_tag0), .busy(busy0)
  );

  mul_pipe #(.WIDTH(W), .CPA_ALGORITHM(1), .TAG_WIDTH(TW)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready), .out_result(out_result1), .out_tag(out_tag1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit products of extended operands, high or low word selected.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic [TW-1:0] tg);
    check({tag, ".v0"}, {63'h0, out_valid0}, {63'h0, v});
    check({tag, ".v1"}, {63'h0, out_valid1}, {63'h0, v});
    if (v) begin
      check({tag, ".res0"}, {32'h0, out_result0}, {32'h0, res});
      check({tag, ".res1"}, {32'h0, out_result1}, {32'h0, res});
      check({tag, ".tag0"}, {59'h0, out_tag0}, {59'h0, tg});
      check({tag, ".tag1"}, {59'h0, out_tag1}, {59'h0, tg});
    end
  endtask

  task automatic expect_rdy(input string tag, input logic r);
    check({tag, ".rdy0"}, {63'h0, in_ready0}, {63'h0, r});
    check({tag, ".rdy1"}, {63'h0, in_ready1}, {63'h0, r});
  endtask

  task automatic expect_busy(input string tag, input logic b);
    check({tag, ".busy0"}, {63'h0, busy0}, {63'h0, b});
    check({tag, ".busy1"}, {63'h0, busy1}, {63'h0, b});
  endtask

  // Issue one op into an empty pipe and check the N+3 latency and result.
  task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tg, input logic [31:0] exp);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tg;
    #1;
    expect_rdy({tag, ".acc"}, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    expect_out({tag, ".n1"}, 1'b0, 32'h0, '0);
    tick();
    #1;
    expect_out({tag, ".n2"}, 1'b0, 32'h0, '0);
    tick();
    #1;
    expect_out({tag, ".n3"}, 1'b1, exp, tg);
    $display("txn %s op=%0d a=%h b=%h tag=%0d res=%h", tag, op, a, b, tg, out_result0);
  endtask

  // One cycle of scoreboard bookkeeping, called after inputs are set for the cycle.
  task automatic sb_cycle(output logic fired_in);
    logic [TW+W-1:0] e;
    fired_in = 1'b0;
    #1;
    if (in_valid && in_ready0) begin
      sb_q.push_back({in_tag, ref_model(in_op, in_a, in_b)});
      sent++;
      tag_ctr++;
      fired_in = 1'b1;
    end
    if (out_valid0 && out_ready) begin
      check("sb.nonempty", {63'h0, sb_q.size() != 0}, 64'h1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb.tag0", {59'h0, out_tag0}, {59'h0, e[TW+W-1:W]});
        check("sb.tag1", {59'h0, out_tag1}, {59'h0, e[TW+W-1:W]});
        check("sb.res0", {32'h0, out_result0}, {32'h0, e[W-1:0]});
        check("sb.res1", {32'h0, out_result1}, {32'h0, e[W-1:0]});
        $display("rx tag=%0d res=%h", out_tag0, out_result0);
      end
      recv++;
    end
    tick();
  endtask

  initial begin
    logic fired;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;

    // ---- reset state
    tick(); tick(); tick();
    expect_rdy("rst", 1'b0);
    expect_busy("rst", 1'b0);
    expect_out("rst", 1'b0, 32'h0, '0);
    check("rst.res0", {32'h0, out_result0}, 64'h0);
    check("rst.tag0", {59'h0, out_tag0}, 64'h0);
    rst = 1'b0;
    #1;
    expect_rdy("rst_drop", 1'b1);
    tick();

    // ---- directed products
    run_one("mul_neg1x2",    2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'hFFFF_FFFE);
    run_one("mulhu_neg1x2",  2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2, 32'h0000_0001);
    run_one("mulh_min",      2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    run_one("mulhu_min",     2'b11, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000);
    run_one("mulhsu_min",    2'b10, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'hC000_0000);
    run_one("mulh_ones",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000);
    run_one("mulhu_ones",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    run_one("mulhsu_ones",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);
    run_one("mul_small",     2'b00, 32'h0000_0007, 32'h0000_0006, 5'd9, 32'h0000_002A);
    run_one("mulh_neg2x3",   2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd10, 32'hFFFF_FFFF);
    run_one("mul_x9",        2'b00, 32'h1234_5678, 32'h0000_0009, 5'd11, 32'hA3D7_0A38);
    tick();

    // ---- back-pressure: three accepted, fourth refused, then in-order drain
    d_op[0] = 2'b00; d_a[0] = 32'h3;          d_b[0] = 32'h5;          d_exp[0] = 32'h0000_000F;
    d_op[1] = 2'b11; d_a[1] = 32'hFFFF_FFFF;  d_b[1] = 32'h2;          d_exp[1] = 32'h0000_0001;
    d_op[2] = 2'b01; d_a[2] = 32'h8000_0000;  d_b[2] = 32'h8000_0000;  d_exp[2] = 32'h4000_0000;
    d_op[3] = 2'b10; d_a[3] = 32'hFFFF_FFFF;  d_b[3] = 32'hFFFF_FFFF;  d_exp[3] = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_op = d_op[k]; in_a = d_a[k]; in_b = d_b[k]; in_tag = TW'(k + 1);
      #1;
      expect_rdy($sformatf("bp.issue%0d", k + 1), (k < 3) ? 1'b1 : 1'b0);
      if (k < 3) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_rdy($sformatf("bp.hold%0d", k), 1'b0);
      expect_out($sformatf("bp.hold%0d", k), 1'b1, d_exp[0], 5'd1);
    end
    out_ready = 1'b1;
    #1;
    expect_rdy("bp.release", 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("bp.out%0d", k + 1), 1'b1, d_exp[k], TW'(k + 1));
      $display("txn bp tag=%0d res=%h", out_tag0, out_result0);
      tick();
      in_valid = 1'b0;
      #1;
    end
    expect_out("bp.empty", 1'b0, 32'h0, '0);
    tick();

    // ---- reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = d_op[k]; in_a = d_a[k]; in_b = d_b[k]; in_tag = TW'(k + 20);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    expect_rdy("rst_mid.during", 1'b0);
    expect_busy("rst_mid.before", 1'b1);
    tick();
    expect_out("rst_mid.after", 1'b0, 32'h0, '0);
    expect_busy("rst_mid.after", 1'b0);
    check("rst_mid.res0", {32'h0, out_result0}, 64'h0);
    rst = 1'b0;
    #1;
    expect_rdy("rst_mid.drop", 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out($sformatf("rst_mid.stale%0d", k), 1'b0, 32'h0, '0);
    end

    // ---- flush with every stage full and the output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = d_op[k]; in_a = d_a[k]; in_b = d_b[k]; in_tag = TW'(k + 24);
      tick();
    end
    expect_busy("flush.full", 1'b1);
    flush = 1'b1; in_tag = 5'd30;
    #1;
    expect_rdy("flush.during", 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    expect_busy("flush.after", 1'b0);
    expect_out("flush.after", 1'b0, 32'h0, '0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("flush.noacc%0d", k), 1'b0, 32'h0, '0);
    end
    run_one("flush.next", 2'b00, 32'h0000_0010, 32'h0000_0010, 5'd31, 32'h0000_0100);
    tick(); tick();

    // ---- random mix, random valid/ready
    sent = 0; recv = 0; cyc = 0; tag_ctr = '0;
    in_valid = 1'b0;
    while ((recv < NRAND) && (cyc < 30000)) begin
      if (!in_valid && (sent < NRAND) && ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_op    = 2'($urandom_range(0, 3));
        in_a     = pick_operand();
        in_b     = pick_operand();
        in_tag   = tag_ctr;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sb_cycle(fired);
      if (fired) in_valid = 1'b0;
      cyc++;
    end
    check("rnd.done_in_time", {63'h0, recv >= NRAND}, 64'h1);
    check("rnd.queue_empty", 64'(sb_q.size()), 64'h0);

    // ---- both sides always ready: one result every cycle once the pipe fills
    out_ready = 1'b1;
    recv = 0;
    for (int k = 0; k < NFULL; k++) begin
      in_valid = 1'b1;
      in_op    = 2'($urandom_range(0, 3));
      in_a     = pick_operand();
      in_b     = pick_operand();
      in_tag   = tag_ctr;
      #1;
      expect_rdy($sformatf("full.rdy%0d", k), 1'b1);
      check($sformatf("full.v%0d", k), {63'h0, out_valid0}, {63'h0, k >= 3});
      #(-0);
      sb_cycle(fired);
    end
    in_valid = 1'b0;
    cyc = 0;
    while ((sb_q.size() != 0) && (cyc < 20)) begin
      sb_cycle(fired);
      cyc++;
    end
    check("full.drained", 64'(sb_q.size()), 64'h0);
    check("full.count", 64'(recv), 64'(NFULL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
